vec_lsu_n: RTL
==============

Name: vec_lsu_n

Overview:
Parametrised multi-beat load/store unit for the vector CPU execute stage. It is the successor to the fixed 32/64-bit memory path.
- Moves scalar words and LANES×ELEM_W vectors over a BUS_W data bus, one beat per transaction.
- Supports unit-stride and strided addressing.
- Uses a start/busy/done handshake so pipeline control can stall on it.

Parameters:
LANES, 8, number of vector lanes
ELEM_W, 8, bits per lane; VEC_W = LANES*ELEM_W must be a multiple of BUS_W
BUS_W, 32, memory data bus width (bits); scalar word width
ADDR_W, 32, byte address width
MEM_LAT, 1, read latency in cycles (>=1) from mem_rd_en to valid mem_rd_data

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
start  in  1  request; accepted only in IDLE
op  in  2  0 scalar load, 1 scalar store, 2 vector load, 3 vector store
strided  in  1  1: beat i address = base+i*stride; 0: base+i*(BUS_W/8)
base_addr  in  ADDR_W  byte base address
stride  in  ADDR_W  byte stride (strided mode only)
st_data_esc  in  BUS_W  scalar store data
st_data_vec  in  VEC_W  vector store data
mem_rd_data  in  BUS_W  memory read data
mem_addr  out  ADDR_W  beat address
mem_wr_data  out  BUS_W  beat write data
mem_wr_en  out  1  write strobe, one cycle per store beat
mem_rd_en  out  1  read strobe, one cycle per load beat
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  misalignment flag, valid with done
ld_data_esc  out  BUS_W  scalar load result
ld_data_vec  out  VEC_W  vector load result

Behaviour:
- Reset (reset=0 at an edge): state IDLE. All outputs 0, including ld_data_* and beat/latency counters. Reset mid-operation aborts immediately; no further strobes.
- BEATS = 1 for scalar ops and VEC_W/BUS_W for vector ops.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - start=1 at an edge latches op, strided, base_addr, stride and store data, and clears the beat index.
  - Goes to REQ, or to DONE with err=1 if base_addr[log2(BUS_W/8)-1:0] != 0. An erred op issues no strobes.
  - With strided=1, a misaligned stride also sets err.
- REQ:
  - Drives mem_addr = base + i*step, computed modulo 2^ADDR_W; wrap-around is legal.
  - Store: mem_wr_en=1 and mem_wr_data = beat i slice (beat 0 = bits [BUS_W-1:0]). Scalar store sends st_data_esc. Then i++; after the last beat go to DONE, else stay in REQ.
  - Load: mem_rd_en=1, then go to WAIT.
- WAIT:
  - Counts MEM_LAT cycles after the rd_en cycle, then captures mem_rd_data into slice i of ld_data_vec, or into ld_data_esc for a scalar load.
  - Then i++ and go to REQ, or to DONE after the last beat.
  - mem_addr holds its value during WAIT. Strobes are 0.
- DONE: done=1, busy=1 for one cycle, then IDLE.
- start while busy (including DONE) is ignored and never queued.
- Outside REQ: mem_wr_en=0, mem_rd_en=0; mem_addr and mem_wr_data hold their last value.
- ld_data_* are updated only by load beats and hold until overwritten.
  - Vector load overwrites ld_data_vec slices only; ld_data_esc is unchanged.
  - Scalar load updates only ld_data_esc.
- Latency with start accepted at edge 0:
  - Vector store: wr cycles 1..BEATS, done at cycle BEATS+1.
  - Vector load: done at cycle BEATS*(MEM_LAT+1)+1.
  - Err: done at cycle 1.
- err is 0 whenever done=0.

Decomposition:
- Shared package vec_mem_types holds:
  - lsu_op_t enum: LD_ESC, ST_ESC, LD_VEC, ST_VEC.
  - lsu_state_t enum: IDLE, REQ, WAIT, DONE.
  - Function beats_of(op).
- One sub-module: lsu_addr_gen (base, step, beat index -> address; alignment check), purely combinational.
- FSM, counters and packing stay in vec_lsu_n.

Test Plan:
- Defaults, vector store: base=0x100, strided=0, st_data_vec=0x1122334455667788 → cycle 1: addr 0x100, data 0x55667788, wr_en=1; cycle 2: addr 0x104, data 0x11223344; cycle 3: done=1, err=0.
- Vector load, strided: base=0x200, stride=0x40; memory returns 0xAAAA0001 then 0xBBBB0002 → rd at 0x200 and 0x240; done at cycle 5; ld_data_vec=0xBBBB0002AAAA0001.
- Misaligned scalar load: base=0x102 → done=1 and err=1 at cycle 1; no rd_en ever asserted; ld_data_esc unchanged.
- Wrap: base=0xFFFFFFFC, vector store → beat addresses 0xFFFFFFFC then 0x00000000; no error.
- start pulsed every cycle during a vector load → exactly one operation and one done pulse; extra starts ignored.
- Reset: drive reset=0 during cycle 2 of a vector store → next edge: busy=0, wr_en=0, all outputs 0; a new start after reset=1 completes normally.

Source files
------------

// File: rtl/vec_lsu_n_pkg.sv
// Shared types for the vector load/store path: operation codes, FSM states and beat helpers.
package vec_mem_types;

    typedef enum logic [1:0] {
        LD_ESC = 2'd0,
        ST_ESC = 2'd1,
        LD_VEC = 2'd2,
        ST_VEC = 2'd3
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    function automatic int unsigned beats_of(lsu_op_t op, int unsigned vec_beats);
        return (op == LD_VEC || op == ST_VEC) ? vec_beats : 32'd1;
    endfunction

    function automatic logic is_load(lsu_op_t op);
        return (op == LD_ESC || op == LD_VEC);
    endfunction

    function automatic logic is_vec(lsu_op_t op);
        return (op == LD_VEC || op == ST_VEC);
    endfunction

endpackage

// File: rtl/vec_lsu_n_if.sv
// Request/response and memory-side signals of the vector LSU, bundled with modports.
interface vec_lsu_n_if #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned BUS_W  = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned VEC_W = LANES * ELEM_W;

    logic              start;
    logic [1:0]        op;
    logic              strided;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [BUS_W-1:0]  st_data_esc;
    logic [VEC_W-1:0]  st_data_vec;
    logic [BUS_W-1:0]  mem_rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS_W-1:0]  mem_wr_data;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [BUS_W-1:0]  ld_data_esc;
    logic [VEC_W-1:0]  ld_data_vec;

    modport slave (
        input  start, op, strided, base_addr, stride, st_data_esc, st_data_vec, mem_rd_data,
        output mem_addr, mem_wr_data, mem_wr_en, mem_rd_en, busy, done, err,
               ld_data_esc, ld_data_vec
    );

    modport master (
        output start, op, strided, base_addr, stride, st_data_esc, st_data_vec, mem_rd_data,
        input  mem_addr, mem_wr_data, mem_wr_en, mem_rd_en, busy, done, err,
               ld_data_esc, ld_data_vec
    );

endinterface

// File: rtl/vec_lsu_n_addr_gen.sv
// Beat address generator: base + idx*step (wrapping), plus word-alignment check.
module lsu_addr_gen #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BUS_W  = 32,
    parameter int unsigned IDX_W  = 1
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              strided,
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic              misaligned
);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BUS_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BUS_W / 8 - 1);

    logic [ADDR_W-1:0] step;

    always_comb begin
        step       = strided ? stride : WORD_BYTES;
        addr       = base + step * ADDR_W'(idx);
        misaligned = (|(base & ALIGN_MASK)) | (strided & (|(stride & ALIGN_MASK)));
    end

endmodule

// File: rtl/vec_lsu_n.sv
// Multi-beat scalar/vector load-store unit with start/busy/done handshake.
module vec_lsu_n
    import vec_mem_types::*;
#(
    parameter int unsigned LANES   = 8,
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned BUS_W   = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic        clk,
    input logic        reset,
    vec_lsu_n_if.slave bus
);
    localparam int unsigned VEC_W     = LANES * ELEM_W;
    localparam int unsigned VEC_BEATS = VEC_W / BUS_W;
    localparam int unsigned IDX_W     = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
    localparam int unsigned LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q, op_d;
    logic              strided_q, strided_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [BUS_W-1:0]  st_esc_q, st_esc_d;
    logic [VEC_W-1:0]  st_vec_q, st_vec_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BUS_W-1:0]  mem_wr_data_q, mem_wr_data_d;
    logic [BUS_W-1:0]  ld_esc_q, ld_esc_d;
    logic [VEC_W-1:0]  ld_vec_q, ld_vec_d;

    logic              rd_en, wr_en;
    logic              last_beat;
    logic [BUS_W-1:0]  beat_wr_data;

    logic [ADDR_W-1:0] gen_base, gen_stride, gen_addr;
    logic              gen_strided, gen_misaligned;

    // In IDLE the generator checks the incoming request; afterwards it walks the latched one.
    assign gen_base    = (state_q == IDLE) ? bus.base_addr : base_q;
    assign gen_stride  = (state_q == IDLE) ? bus.stride    : stride_q;
    assign gen_strided = (state_q == IDLE) ? bus.strided   : strided_q;

    lsu_addr_gen #(
        .ADDR_W (ADDR_W),
        .BUS_W  (BUS_W),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .base       (gen_base),
        .stride     (gen_stride),
        .strided    (gen_strided),
        .idx        (idx_q),
        .addr       (gen_addr),
        .misaligned (gen_misaligned)
    );

    assign last_beat    = ((32'(idx_q) + 32'd1) == beats_of(op_q, VEC_BEATS));
    assign beat_wr_data = is_vec(op_q) ? st_vec_q[32'(idx_q) * BUS_W +: BUS_W] : st_esc_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        strided_d     = strided_q;
        base_d        = base_q;
        stride_d      = stride_q;
        st_esc_d      = st_esc_q;
        st_vec_d      = st_vec_q;
        idx_d         = idx_q;
        lat_d         = lat_q;
        err_d         = err_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        ld_esc_d      = ld_esc_q;
        ld_vec_d      = ld_vec_q;
        rd_en         = 1'b0;
        wr_en         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d      = lsu_op_t'(bus.op);
                    strided_d = bus.strided;
                    base_d    = bus.base_addr;
                    stride_d  = bus.stride;
                    st_esc_d  = bus.st_data_esc;
                    st_vec_d  = bus.st_data_vec;
                    idx_d     = '0;
                    lat_d     = '0;
                    err_d     = gen_misaligned;
                    state_d   = gen_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                mem_addr_d = gen_addr;
                if (is_load(op_q)) begin
                    rd_en   = 1'b1;
                    lat_d   = '0;
                    state_d = WAIT;
                end else begin
                    wr_en         = 1'b1;
                    mem_wr_data_d = beat_wr_data;
                    idx_d         = idx_q + IDX_W'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    if (is_vec(op_q)) begin
                        ld_vec_d[32'(idx_q) * BUS_W +: BUS_W] = bus.mem_rd_data;
                    end else begin
                        ld_esc_d = bus.mem_rd_data;
                    end
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = last_beat ? DONE : REQ;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            op_q          <= LD_ESC;
            strided_q     <= 1'b0;
            base_q        <= '0;
            stride_q      <= '0;
            st_esc_q      <= '0;
            st_vec_q      <= '0;
            idx_q         <= '0;
            lat_q         <= '0;
            err_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            ld_esc_q      <= '0;
            ld_vec_q      <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            strided_q     <= strided_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            st_esc_q      <= st_esc_d;
            st_vec_q      <= st_vec_d;
            idx_q         <= idx_d;
            lat_q         <= lat_d;
            err_q         <= err_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            ld_esc_q      <= ld_esc_d;
            ld_vec_q      <= ld_vec_d;
        end
    end

    // Address/data are live in REQ and otherwise show the last issued beat.
    assign bus.mem_addr    = (state_q == REQ) ? gen_addr : mem_addr_q;
    assign bus.mem_wr_data = wr_en ? beat_wr_data : mem_wr_data_q;
    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_rd_en   = rd_en;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.err         = (state_q == DONE) & err_q;
    assign bus.ld_data_esc = ld_esc_q;
    assign bus.ld_data_vec = ld_vec_q;

endmodule
